// File: rtl/fifo_pkg.sv
// Shared wrap-pointer arithmetic for the circular FIFO read and write handlers.
// Pointers are {wrap, addr}; both handlers call these functions so the wrap
// rules cannot drift apart between the two sides.
package fifo_pkg;

  localparam int unsigned FIFO_D     = 8;
  localparam int unsigned FIFO_DEPTH = 90;

  // Widest pointer the helpers handle; callers truncate results to their own width.
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;
  typedef logic [PTR_MAX_W:0]   cnt_t;

  // Wrap-aware increment: the address runs 0..depth-1, then returns to 0 and
  // the wrap bit (bit d-1) toggles.
  function automatic ptr_t ptr_next(input ptr_t ptr, input int unsigned depth,
                                    input int unsigned d);
    ptr_t wrap_bit;
    ptr_t addr_mask;
    wrap_bit  = ptr_t'(1) << (d - 1);
    addr_mask = wrap_bit - ptr_t'(1);
    if ((ptr & addr_mask) == ptr_t'(depth - 1))
      ptr_next = (ptr & wrap_bit) ^ wrap_bit;
    else
      ptr_next = ptr + ptr_t'(1);
  endfunction

  // Occupancy between a write and a read pointer, 0..depth. Computed one bit
  // wider than the pointer so the depth - r_addr + w_addr form cannot overflow.
  function automatic ptr_t ptr_count(input ptr_t wptr, input ptr_t rptr,
                                     input int unsigned depth, input int unsigned d);
    ptr_t wrap_bit;
    ptr_t addr_mask;
    cnt_t wa;
    cnt_t ra;
    cnt_t cnt;
    wrap_bit  = ptr_t'(1) << (d - 1);
    addr_mask = wrap_bit - ptr_t'(1);
    wa = {1'b0, wptr & addr_mask};
    ra = {1'b0, rptr & addr_mask};
    if ((wptr & wrap_bit) == (rptr & wrap_bit))
      cnt = wa - ra;
    else
      cnt = cnt_t'(depth) - ra + wa;
    ptr_count = cnt[PTR_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/write_handler_wrap_ptr_counter.sv
// Wrap-bit pointer register: advances by one entry on inc, wrapping the
// address at depth-1 and toggling the wrap bit.
module wrap_ptr_counter
  import fifo_pkg::*;
#(
  parameter int unsigned d     = FIFO_D,
  parameter int unsigned depth = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [d-1:0] ptr
);

  logic [d-1:0] ptr_q;
  logic [d-1:0] ptr_d;

  // Next pointer: hold unless an increment is requested.
  always_comb begin
    ptr_d = ptr_q;
    if (inc)
      ptr_d = d'(ptr_next(ptr_t'(ptr_q), depth, d));
  end

  // Pointer register with synchronous reset to entry 0, wrap 0.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/write_handler.sv
// Write-side pointer and status logic for the circular FIFO.
// Optional build macro WRITE_HANDLER_OVERFLOW_EN: when defined, wr_overflow is
// a sticky flag set by any write attempted while full; otherwise it is tied 0.
module write_handler
  import fifo_pkg::*;
#(
  parameter int unsigned d        = FIFO_D,
  parameter int unsigned depth    = FIFO_DEPTH,
  parameter int unsigned af_level = depth - 2
) (
  input  logic         wrclk,
  input  logic         wrrst,
  input  logic         wren,
  input  logic [d-1:0] rdPtr,
  output logic [d-1:0] wrPtr,
  output logic [d-2:0] wr_addr,
  output logic         wr_strobe,
  output logic         fifo_full,
  output logic         fifo_almost_full,
  output logic [d-1:0] wr_count,
  output logic         wr_overflow
);

  localparam logic [d-1:0] AF_LVL = d'(af_level);

  logic [d-1:0] wr_ptr;
  logic         accept;

  wrap_ptr_counter #(
    .d     (d),
    .depth (depth)
  ) u_wr_ptr (
    .clk (wrclk),
    .rst (wrrst),
    .inc (accept),
    .ptr (wr_ptr)
  );

  // Flags and count are purely combinational from the current pointers, so a
  // read that frees space is seen by the write side in the following cycle.
  always_comb begin
    fifo_full        = (wr_ptr[d-1] != rdPtr[d-1]) && (wr_ptr[d-2:0] == rdPtr[d-2:0]);
    wr_count         = d'(ptr_count(ptr_t'(wr_ptr), ptr_t'(rdPtr), depth, d));
    fifo_almost_full = (wr_count >= AF_LVL);
    accept           = wren & ~fifo_full;
    wr_strobe        = accept;
    wr_addr          = wr_ptr[d-2:0];
    wrPtr            = wr_ptr;
  end

`ifdef WRITE_HANDLER_OVERFLOW_EN
  logic wr_overflow_q;
  logic wr_overflow_d;

  // Overflow sets on any write attempted while full and only reset clears it.
  always_comb begin
    wr_overflow_d = wr_overflow_q | (wren & fifo_full);
  end

  // Sticky overflow register.
  always_ff @(posedge wrclk) begin
    if (wrrst)
      wr_overflow_q <= 1'b0;
    else
      wr_overflow_q <= wr_overflow_d;
  end

  assign wr_overflow = wr_overflow_q;
`else
  assign wr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_handler.sv
// Bench for write_handler: directed scenarios plus randomized producer/consumer
// traffic, checked every cycle against an occupancy model that tracks the
// write position as an absolute index 0..2*depth-1.
module tb_write_handler;

  localparam int D     = 8;
  localparam int DEPTH = 90;
  localparam int AF    = DEPTH - 2;
  localparam int M     = 2 * DEPTH;

  logic       wrclk = 1'b0;
  logic       wrrst;
  logic       wren;
  logic [7:0] rdPtr;
  logic [7:0] wrPtr;
  logic [6:0] wr_addr;
  logic       wr_strobe;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic [7:0] wr_count;
  logic       wr_overflow;

  int checks   = 0;
  int failures = 0;
  int m_w      = 0;
  bit m_ovf    = 1'b0;
  bit chk_en   = 1'b0;
  logic [31:0] ovf_exp;

  always #5 wrclk = ~wrclk;

  write_handler #(
    .d        (D),
    .depth    (DEPTH),
    .af_level (AF)
  ) dut (
    .wrclk            (wrclk),
    .wrrst            (wrrst),
    .wren             (wren),
    .rdPtr            (rdPtr),
    .wrPtr            (wrPtr),
    .wr_addr          (wr_addr),
    .wr_strobe        (wr_strobe),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .wr_count         (wr_count),
    .wr_overflow      (wr_overflow)
  );

  function automatic int r_abs(input logic [7:0] p);
    return (p[7] ? DEPTH : 0) + int'(p[6:0]);
  endfunction

  function automatic logic [7:0] enc(input int a);
    logic [6:0] addr;
    addr = 7'(a % DEPTH);
    return {(a >= DEPTH), addr};
  endfunction

  function automatic int m_occ();
    return (m_w - r_abs(rdPtr) + M) % M;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute write index advances on accepted writes.
  always @(posedge wrclk) begin
    if (wrrst) begin
      m_w   <= 0;
      m_ovf <= 1'b0;
    end else begin
      if (wren && m_occ() != DEPTH)
        m_w <= (m_w + 1) % M;
`ifdef WRITE_HANDLER_OVERFLOW_EN
      if (wren && m_occ() == DEPTH)
        m_ovf <= 1'b1;
`endif
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge wrclk) begin
    if (chk_en && !wrrst) begin
      int occ;
      occ = m_occ();
      check("wrPtr",       wrPtr,            enc(m_w));
      check("wr_addr",     wr_addr,          m_w % DEPTH);
      check("wr_count",    wr_count,         occ);
      check("fifo_full",   fifo_full,        occ == DEPTH);
      check("almost_full", fifo_almost_full, occ >= AF);
      check("wr_strobe",   wr_strobe,        wren && (occ != DEPTH));
      check("wr_overflow", wr_overflow,      m_ovf);
    end
  end

  task automatic step(input logic w, input logic [7:0] rp);
    wren  = w;
    rdPtr = rp;
    @(posedge wrclk);
    #1;
  endtask

  task automatic do_reset();
    wrrst = 1'b1;
    step(1'b0, 8'h00);
    wrrst = 1'b0;
  endtask

  initial begin
    int r;
`ifdef WRITE_HANDLER_OVERFLOW_EN
    ovf_exp = 32'd1;
`else
    ovf_exp = 32'd0;
`endif
    wrrst = 1'b1;
    wren  = 1'b0;
    rdPtr = 8'h00;
    repeat (2) @(posedge wrclk);
    #1;
    check("rst_wrPtr",    wrPtr,       32'h00);
    check("rst_count",    wr_count,    32'd0);
    check("rst_full",     fifo_full,   32'd0);
    check("rst_overflow", wr_overflow, 32'd0);
    wrrst  = 1'b0;
    chk_en = 1'b1;

    // Fill to full with the reader parked at 0.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 8'h00);
      if (i == 87) check("af_after_87", fifo_almost_full, 32'd0);
      if (i == 88) check("af_after_88", fifo_almost_full, 32'd1);
    end
    check("fill_wrPtr", wrPtr,     32'h80);
    check("fill_full",  fifo_full, 32'd1);
    check("fill_count", wr_count,  32'd90);

    // Writes while full are dropped.
    for (int i = 0; i < 3; i++) begin
      wren = 1'b1;
      #1;
      check("ovf_strobe", wr_strobe, 32'd0);
      @(posedge wrclk);
      #1;
      check("ovf_wrPtr", wrPtr, 32'h80);
    end
    check("ovf_flag", wr_overflow, ovf_exp);

    // Release from full: rejected while rdPtr=0, accepted once it advances.
    wren  = 1'b1;
    rdPtr = 8'h00;
    #1;
    check("rel_strobe0", wr_strobe, 32'd0);
    @(posedge wrclk);
    #1;
    check("rel_hold", wrPtr, 32'h80);
    rdPtr = 8'h01;
    #1;
    check("rel_strobe1", wr_strobe, 32'd1);
    @(posedge wrclk);
    #1;
    check("rel_wrPtr", wrPtr,     32'h81);
    check("rel_full",  fifo_full, 32'd1);

    // Wrap-around count.
    do_reset();
    for (int i = 0; i < 89; i++) step(1'b1, 8'h00);
    check("wrap_pre", wrPtr, 32'h59);
    step(1'b1, 8'h05);
    check("wrap_wrPtr", wrPtr,     32'h80);
    check("wrap_count", wr_count,  32'd85);
    check("wrap_full",  fifo_full, 32'd0);

    // Reset mid-fill with a write pending.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'h00);
    check("mid_pre", wrPtr, 32'd40);
    wrrst = 1'b1;
    step(1'b1, 8'h00);
    wrrst = 1'b0;
    wren  = 1'b0;
    #1;
    check("mid_wrPtr", wrPtr,    32'h00);
    check("mid_count", wr_count, 32'd0);

    // Randomized traffic; the reader only advances while data is present.
    r = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(249) == 0) begin
        wrrst = 1'b1;
        r     = 0;
        step(1'($urandom_range(1)), 8'h00);
      end else begin
        wrrst = 1'b0;
        if (((m_w - r + M) % M) > 0 && $urandom_range(99) < 45)
          r = (r + 1) % M;
        step(1'($urandom_range(9) < 7), enc(r));
      end
    end
    wrrst = 1'b0;
    step(1'b0, enc(r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_handler.md
# write_handler

Write-side pointer and flag logic for the team's circular FIFO. It is the counterpart to the read handler. It owns the write pointer, which carries a wrap bit, and advances it on accepted writes. It compares that pointer against the read pointer to raise full, almost-full and occupancy status, and it drives the memory write strobe and address. It sits between the upstream producer and the FIFO storage array. Its `wrPtr` output feeds the read handler's empty comparison.

## Interface
- `d`, 8: pointer width. Bit `d-1` is the wrap bit; bits `d-2:0` are the address.
- `depth`, 90: number of storage entries. Required: 2 ≤ `depth` ≤ 2^(d-1).
- `af_level`, depth-2: occupancy at or above which `fifo_almost_full` asserts.

Ports:
- `wrclk` in 1: write clock. All state changes on the rising edge.
- `wrrst` in 1: reset, synchronous, active-high.
- `wren` in 1: write request from the producer.
- `rdPtr` in d: read pointer from the read handler. Must be synchronous to `wrclk`.
- `wrPtr` out d: registered write pointer, `{wrap, addr}`.
- `wr_addr` out d-1: memory write address, equal to `wrPtr[d-2:0]`.
- `wr_strobe` out 1: memory write enable, equal to `wren & ~fifo_full`.
- `fifo_full` out 1: FIFO full.
- `fifo_almost_full` out 1: occupancy ≥ `af_level`.
- `wr_count` out d: current occupancy, 0..depth.
- `wr_overflow` out 1: sticky overflow flag (see Configuration).

## Operation
- **Accept rule:** a write is accepted when `wren && !fifo_full`.
- **Pointer advance:** on an accepted write:
  - If `wrPtr[d-2:0] < depth-1`, the address increments and the wrap bit holds.
  - If `wrPtr[d-2:0] == depth-1`, the address goes to 0 and the wrap bit toggles.
- **No accept:** the pointer holds.
- **Full:** `fifo_full` is set when the wrap bits differ and the address bits are equal. It is combinational from `wrPtr` and `rdPtr`.
- **Empty equivalence:** when the wrap bits are equal and the addresses are equal, `wr_count` = 0.
- **Occupancy:**
  - Wrap bits equal: `wr_count = w_addr - r_addr`.
  - Wrap bits differ: `wr_count = depth - r_addr + w_addr`.
  - Computed at d+1 bits internally, truncated to d bits; the result never exceeds `depth`.
- **Almost-full:** `fifo_almost_full = (wr_count >= af_level)`, combinational.
- **Write while full:** the write is dropped. The pointer, storage and `wr_strobe` are unaffected, and `wr_strobe` = 0.
- **Simultaneous read and write while full:** no bypass. `fifo_full` reflects the current `rdPtr`, so the write is rejected this cycle and accepted on the next cycle once `rdPtr` has advanced.
- **Reset mid-operation:** the next edge forces `wrPtr` = 0. Flags then recompute from `rdPtr`; if the read side is reset together, `fifo_full` = 0 and `wr_count` = 0.

## Timing
- **Reset values:**
  - `wrPtr` = 0, `wr_addr` = 0, `wr_overflow` = 0.
  - `fifo_full`, `fifo_almost_full` and `wr_count` are derived; they are 0 when `rdPtr` = 0.
  - `wr_strobe` = `wren`.
- **Registered outputs:** only `wrPtr` and `wr_overflow`. All other outputs are combinational, with zero-cycle latency from the current pointers.
- **Write latency:** the data at `wr_addr` is written on the same edge as `wr_strobe`. `wrPtr` reflects the new entry one cycle later.
- **Full timing:** `fifo_full` asserts combinationally in the cycle after the write that fills entry `depth`.
- **Throughput:** one write per cycle, sustained until full.

## Configuration
- Macro: `WRITE_HANDLER_OVERFLOW_EN`.
- **Defined:** `wr_overflow` is a register that sets on any cycle with `wren && fifo_full`. It clears only on `wrrst`.
- **Undefined:** `wr_overflow` is tied to 0 and no register is inferred. The port list is identical in both builds.

## Structure
- **Shared package `fifo_pkg`:**
  - Default `d` and `depth` constants.
  - Function `ptr_next(ptr, depth)`, the wrap-aware increment.
  - Function `ptr_count(wptr, rptr, depth)`, the occupancy calculation.
  - The read handler uses the same package, so the wrap arithmetic is identical on both sides.
- **Sub-module `wrap_ptr_counter`:** parameterised by `d` and `depth`, with inputs `clk`, `rst` and `inc` and output `ptr`. It holds the pointer register and wrap logic; the top level adds the flags, count and overflow logic.

## Test plan
- **Reset:** assert `wrrst` for 2 cycles with `rdPtr` = 0 → `wrPtr` = 0, `wr_count` = 0, `fifo_full` = 0, `wr_overflow` = 0.
- **Fill to full:** 90 consecutive writes with `rdPtr` held at 0 → `wrPtr` = 0x80, `fifo_full` = 1, `wr_count` = 90. `fifo_almost_full` first asserts after write 88.
- **Overflow drop:** 3 further writes while full → `wrPtr` stays 0x80 and `wr_strobe` = 0. With the macro defined, `wr_overflow` = 1; with it undefined, `wr_overflow` = 0.
- **Wrap-around count:** `rdPtr` = 0x05, `wrPtr` at 0x59 (address 89), one write → `wrPtr` = 0x80, `wr_count` = 85, `fifo_full` = 0.
- **Release from full:** full at `wrPtr` = 0x80 with `rdPtr` = 0x00, then `rdPtr` → 0x01 while `wren` is held → the write is rejected in the `rdPtr` = 0x00 cycle. It is accepted in the next cycle, `wrPtr` = 0x81, `fifo_full` = 1 again.
- **Reset mid-fill:** after 40 writes, pulse `wrrst` while `wren` = 1 and `rdPtr` = 0 → `wrPtr` = 0 on the next edge and `wr_count` = 0. The write in the reset cycle is not counted.
